// File: rtl/fractal_sync_tx_mc_if.sv
// Bundle of response-input, pop/clear control and per-channel head/status signals
// for the multi-channel fractal sync transmit stage.
interface fractal_sync_tx_mc_if #(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned DST_W      = 4,
   parameter int unsigned FIFO_DEPTH = 2
);
   localparam int unsigned ODW   = DST_W - N_CH;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                    rsp_wake_i;
   logic                    rsp_error_i;
   logic [DST_W-1:0]        rsp_dst_i;
   logic [N_CH-1:0]         pop_i;
   logic                    clear_i;
   logic [N_CH-1:0]         empty_o;
   logic [N_CH-1:0]         wake_o;
   logic [N_CH-1:0]         error_o;
   logic [N_CH*ODW-1:0]     dst_o;
   logic [N_CH*CNT_W-1:0]   level_o;
   logic [N_CH-1:0]         overflow_o;
   logic [N_CH-1:0]         underflow_o;
   logic                    err_sticky_o;

   modport master (
      output rsp_wake_i, rsp_error_i, rsp_dst_i, pop_i, clear_i,
      input  empty_o, wake_o, error_o, dst_o, level_o, overflow_o, underflow_o, err_sticky_o
   );

   modport slave (
      input  rsp_wake_i, rsp_error_i, rsp_dst_i, pop_i, clear_i,
      output empty_o, wake_o, error_o, dst_o, level_o, overflow_o, underflow_o, err_sticky_o
   );
endinterface

// File: rtl/fractal_sync_tx_mc.sv
// Multi-channel fractal sync transmit stage: decodes one-hot dst bits, pushes the
// next-level response into per-channel FIFOs and tracks occupancy and errors.
module fractal_sync_tx_mc #(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned DST_W      = 4,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned COMB_IN    = 0
) (
   input logic                clk_i,
   input logic                rst_ni,
   fractal_sync_tx_mc_if.slave bus
);
   localparam int unsigned ODW   = DST_W - N_CH;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned EW    = ODW + 2;

   logic [N_CH-1:0] push_d;
   logic [N_CH-1:0] push;
   logic [EW-1:0]   elem;

   logic [N_CH-1:0]       ovf;
   logic [N_CH-1:0]       unf;
   logic [N_CH-1:0]       empty_v;
   logic [N_CH-1:0]       wake_v;
   logic [N_CH-1:0]       err_v;
   logic [N_CH*ODW-1:0]   dst_v;
   logic [N_CH*CNT_W-1:0] level_v;
   logic                  err_q;

   assign push_d = bus.rsp_dst_i[N_CH-1:0] & {N_CH{bus.rsp_wake_i}};

   // Input stage: pass-through or one register slice (payload only loads on wake)
   generate
      if (COMB_IN != 0) begin : g_comb_in
         assign push = push_d;
         assign elem = {bus.rsp_wake_i, bus.rsp_error_i, bus.rsp_dst_i[DST_W-1:N_CH]};
      end else begin : g_reg_in
         logic [EW-1:0]   elem_q;
         logic [N_CH-1:0] push_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               elem_q <= '0;
               push_q <= '0;
            end else begin
               push_q <= push_d;
               if (bus.rsp_wake_i) begin
                  elem_q <= {bus.rsp_wake_i, bus.rsp_error_i, bus.rsp_dst_i[DST_W-1:N_CH]};
               end
            end
         end

         assign push = push_q;
         assign elem = elem_q;
      end
   endgenerate

   generate
      for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
         logic [EW-1:0]    mem [FIFO_DEPTH];
         logic [PTR_W-1:0] wr_ptr_q;
         logic [PTR_W-1:0] rd_ptr_q;
         logic [CNT_W-1:0] level_q;
         logic             empty;
         logic             full;
         logic             push_ok;
         logic             pop_ok;
         logic [EW-1:0]    head;

         assign empty   = (level_q == '0);
         assign full    = (level_q == CNT_W'(FIFO_DEPTH));
         // A pop frees the slot in the same edge, so a full FIFO still accepts push+pop
         assign push_ok = push[c] & (~full | bus.pop_i[c]);
         assign pop_ok  = bus.pop_i[c] & ~empty;
         assign ovf[c]  = push[c] & full & ~bus.pop_i[c];
         assign unf[c]  = bus.pop_i[c] & empty;

         always_ff @(posedge clk_i) begin
            if (push_ok) begin
               mem[wr_ptr_q] <= elem;
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               level_q  <= '0;
            end else begin
               if (push_ok) begin
                  wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
               end
               if (pop_ok) begin
                  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
               end
               case ({push_ok, pop_ok})
                  2'b10:   level_q <= level_q + CNT_W'(1);
                  2'b01:   level_q <= level_q - CNT_W'(1);
                  default: level_q <= level_q;
               endcase
            end
         end

         assign head = empty ? '0 : mem[rd_ptr_q];

         assign empty_v[c]                 = empty;
         assign wake_v[c]                  = head[EW-1];
         assign err_v[c]                   = head[EW-2];
         assign dst_v[c*ODW +: ODW]        = head[ODW-1:0];
         assign level_v[c*CNT_W +: CNT_W]  = level_q;
      end
   endgenerate

   // Sticky error summary; a new event outranks a same-cycle clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if ((|ovf) || (|unf)) begin
         err_q <= 1'b1;
      end else if (bus.clear_i) begin
         err_q <= 1'b0;
      end
   end

   assign bus.empty_o      = empty_v;
   assign bus.wake_o       = wake_v;
   assign bus.error_o      = err_v;
   assign bus.dst_o        = dst_v;
   assign bus.level_o      = level_v;
   assign bus.overflow_o   = ovf;
   assign bus.underflow_o  = unf;
   assign bus.err_sticky_o = err_q;
endmodule

// File: tb/tb_fractal_sync_tx_mc.sv
// Bench for fractal_sync_tx_mc: registered-input depth-2 and combinational-input
// depth-3 instances driven in lockstep against a queue-based reference model.
module tb_fractal_sync_tx_mc;
   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   fractal_sync_tx_mc_if #(.N_CH(4), .DST_W(8), .FIFO_DEPTH(2)) bus0 ();
   fractal_sync_tx_mc_if #(.N_CH(4), .DST_W(8), .FIFO_DEPTH(3)) bus1 ();

   fractal_sync_tx_mc #(.N_CH(4), .DST_W(8), .FIFO_DEPTH(2), .COMB_IN(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .bus(bus0.slave));
   fractal_sync_tx_mc #(.N_CH(4), .DST_W(8), .FIFO_DEPTH(3), .COMB_IN(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;

   logic       in_wake, in_err, in_clr;
   logic [7:0] in_dst;
   logic [3:0] in_pop;

   logic [3:0]  a_empty [2];
   logic [3:0]  a_wake  [2];
   logic [3:0]  a_err   [2];
   logic [3:0]  a_ovf   [2];
   logic [3:0]  a_unf   [2];
   logic [15:0] a_dst   [2];
   logic [7:0]  a_lvl   [2];
   logic        a_st    [2];

   assign a_empty[0] = bus0.empty_o;      assign a_empty[1] = bus1.empty_o;
   assign a_wake[0]  = bus0.wake_o;       assign a_wake[1]  = bus1.wake_o;
   assign a_err[0]   = bus0.error_o;      assign a_err[1]   = bus1.error_o;
   assign a_ovf[0]   = bus0.overflow_o;   assign a_ovf[1]   = bus1.overflow_o;
   assign a_unf[0]   = bus0.underflow_o;  assign a_unf[1]   = bus1.underflow_o;
   assign a_dst[0]   = bus0.dst_o;        assign a_dst[1]   = bus1.dst_o;
   assign a_lvl[0]   = bus0.level_o;      assign a_lvl[1]   = bus1.level_o;
   assign a_st[0]    = bus0.err_sticky_o; assign a_st[1]    = bus1.err_sticky_o;

   // Reference model: one queue of {wake,error,dst[3:0]} per (dut,channel)
   logic [5:0] mq [8][$];
   logic [3:0] pend_push;
   logic [5:0] pend_elem;
   logic       sticky_m [2];

   function automatic int depth_of(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic logic [3:0] eff_push(input int d);
      if (d == 0) return pend_push;
      return in_wake ? in_dst[3:0] : 4'h0;
   endfunction

   function automatic logic [5:0] eff_elem(input int d);
      if (d == 0) return pend_elem;
      return {in_wake, in_err, in_dst[7:4]};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic w, input logic e, input logic [7:0] dd,
                         input logic [3:0] p, input logic clr);
      in_wake = w; in_err = e; in_dst = dd; in_pop = p; in_clr = clr;
      bus0.rsp_wake_i = w; bus0.rsp_error_i = e; bus0.rsp_dst_i = dd;
      bus0.pop_i = p; bus0.clear_i = clr;
      bus1.rsp_wake_i = w; bus1.rsp_error_i = e; bus1.rsp_dst_i = dd;
      bus1.pop_i = p; bus1.clear_i = clr;
   endtask

   task automatic model_check(input int d);
      logic [3:0] e_empty, e_wake, e_err, e_ovf, e_unf, p;
      logic [15:0] e_dst;
      logic [7:0]  e_lvl;
      p = eff_push(d);
      for (int c = 0; c < 4; c++) begin
         int sz;
         logic [5:0] h;
         sz = mq[d*4+c].size();
         h  = (sz > 0) ? mq[d*4+c][0] : 6'h0;
         e_empty[c] = (sz == 0);
         e_wake[c]  = h[5];
         e_err[c]   = h[4];
         e_dst[c*4 +: 4] = h[3:0];
         e_lvl[c*2 +: 2] = 2'(sz);
         e_ovf[c] = p[c] && (sz == depth_of(d)) && !in_pop[c];
         e_unf[c] = in_pop[c] && (sz == 0);
      end
      chk($sformatf("m%0d empty", d), 16'(a_empty[d]), 16'(e_empty));
      chk($sformatf("m%0d wake", d),  16'(a_wake[d]),  16'(e_wake));
      chk($sformatf("m%0d error", d), 16'(a_err[d]),   16'(e_err));
      chk($sformatf("m%0d dst", d),   a_dst[d],        e_dst);
      chk($sformatf("m%0d level", d), 16'(a_lvl[d]),   16'(e_lvl));
      chk($sformatf("m%0d ovf", d),   16'(a_ovf[d]),   16'(e_ovf));
      chk($sformatf("m%0d unf", d),   16'(a_unf[d]),   16'(e_unf));
      chk($sformatf("m%0d sticky", d), 16'(a_st[d]),   16'(sticky_m[d]));
   endtask

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         logic [3:0] p;
         logic [5:0] el;
         logic ev;
         p  = eff_push(d);
         el = eff_elem(d);
         ev = 1'b0;
         for (int c = 0; c < 4; c++) begin
            int sz;
            sz = mq[d*4+c].size();
            if ((p[c] && sz == depth_of(d) && !in_pop[c]) || (in_pop[c] && sz == 0)) ev = 1'b1;
            if (in_pop[c] && sz > 0) void'(mq[d*4+c].pop_front());
            if (p[c] && (sz < depth_of(d) || in_pop[c])) mq[d*4+c].push_back(el);
         end
         if (ev) sticky_m[d] = 1'b1;
         else if (in_clr) sticky_m[d] = 1'b0;
      end
      pend_push = in_wake ? in_dst[3:0] : 4'h0;
      if (in_wake) pend_elem = {1'b1, in_err, in_dst[7:4]};
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mq[i].delete();
      pend_push = '0; pend_elem = '0;
      sticky_m[0] = 1'b0; sticky_m[1] = 1'b0;
   endtask

   task automatic sample();
      @(negedge clk);
      model_check(0);
      model_check(1);
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   typedef struct {
      logic        wake;
      logic        err;
      logic [7:0]  dst;
      logic [3:0]  pop;
      logic        clr;
      logic [3:0]  e_empty;
      logic [15:0] e_dst;
      logic [7:0]  e_lvl;
      logic [3:0]  e_ovf;
      logic [3:0]  e_unf;
      logic        e_st;
   } row_t;

   row_t tbl [29];

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Directed expectations for the registered-input depth-2 instance
      tbl[0]  = '{1'b1,1'b0,8'hA4,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};
      tbl[1]  = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};
      tbl[2]  = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hB,16'h0A00,8'h10,4'h0,4'h0,1'b0};
      tbl[3]  = '{1'b0,1'b0,8'h00,4'h4,1'b0, 4'hB,16'h0A00,8'h10,4'h0,4'h0,1'b0};
      tbl[4]  = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};
      tbl[5]  = '{1'b1,1'b0,8'h11,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};
      tbl[6]  = '{1'b1,1'b0,8'h21,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};
      tbl[7]  = '{1'b1,1'b0,8'h31,4'h0,1'b0, 4'hE,16'h0001,8'h01,4'h0,4'h0,1'b0};
      tbl[8]  = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hE,16'h0001,8'h02,4'h1,4'h0,1'b0};
      tbl[9]  = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hE,16'h0001,8'h02,4'h0,4'h0,1'b1};
      tbl[10] = '{1'b0,1'b0,8'h00,4'h1,1'b0, 4'hE,16'h0001,8'h02,4'h0,4'h0,1'b1};
      tbl[11] = '{1'b0,1'b0,8'h00,4'h1,1'b0, 4'hE,16'h0002,8'h01,4'h0,4'h0,1'b1};
      tbl[12] = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b1};
      tbl[13] = '{1'b1,1'b0,8'h41,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b1};
      tbl[14] = '{1'b1,1'b0,8'h51,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b1};
      tbl[15] = '{1'b1,1'b0,8'h61,4'h0,1'b0, 4'hE,16'h0004,8'h01,4'h0,4'h0,1'b1};
      tbl[16] = '{1'b0,1'b0,8'h00,4'h1,1'b0, 4'hE,16'h0004,8'h02,4'h0,4'h0,1'b1};
      tbl[17] = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hE,16'h0005,8'h02,4'h0,4'h0,1'b1};
      tbl[18] = '{1'b0,1'b0,8'h00,4'h1,1'b0, 4'hE,16'h0005,8'h02,4'h0,4'h0,1'b1};
      tbl[19] = '{1'b0,1'b0,8'h00,4'h1,1'b0, 4'hE,16'h0006,8'h01,4'h0,4'h0,1'b1};
      tbl[20] = '{1'b0,1'b0,8'h00,4'h0,1'b1, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b1};
      tbl[21] = '{1'b0,1'b0,8'h00,4'h2,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h2,1'b0};
      tbl[22] = '{1'b1,1'b0,8'h72,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b1};
      tbl[23] = '{1'b0,1'b0,8'h00,4'h2,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h2,1'b1};
      tbl[24] = '{1'b0,1'b0,8'h00,4'h8,1'b1, 4'hD,16'h0070,8'h04,4'h0,4'h8,1'b1};
      tbl[25] = '{1'b0,1'b0,8'h00,4'h0,1'b1, 4'hD,16'h0070,8'h04,4'h0,4'h0,1'b1};
      tbl[26] = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hD,16'h0070,8'h04,4'h0,4'h0,1'b0};
      tbl[27] = '{1'b0,1'b0,8'h00,4'h2,1'b0, 4'hD,16'h0070,8'h04,4'h0,4'h0,1'b0};
      tbl[28] = '{1'b0,1'b0,8'h00,4'h0,1'b0, 4'hF,16'h0000,8'h00,4'h0,4'h0,1'b0};

      model_reset();
      set_in(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_check(0);
      model_check(1);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         set_in(tbl[i].wake, tbl[i].err, tbl[i].dst, tbl[i].pop, tbl[i].clr);
         sample();
         chk($sformatf("t%0d empty", i), 16'(bus0.empty_o), 16'(tbl[i].e_empty));
         chk($sformatf("t%0d dst", i),   bus0.dst_o,        tbl[i].e_dst);
         chk($sformatf("t%0d level", i), 16'(bus0.level_o), 16'(tbl[i].e_lvl));
         chk($sformatf("t%0d ovf", i),   16'(bus0.overflow_o),  16'(tbl[i].e_ovf));
         chk($sformatf("t%0d unf", i),   16'(bus0.underflow_o), 16'(tbl[i].e_unf));
         chk($sformatf("t%0d sticky", i), 16'(bus0.err_sticky_o), 16'(tbl[i].e_st));
         advance();
      end

      // Broadcast to all channels on the combinational-input instance
      set_in(1'b1, 1'b1, 8'h3F, 4'h0, 1'b0);
      step();
      set_in(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      sample();
      chk("bcast empty", 16'(bus1.empty_o), 16'h0000);
      chk("bcast dst",   bus1.dst_o,        16'h3333);
      chk("bcast error", 16'(bus1.error_o), 16'h000F);
      chk("bcast wake",  16'(bus1.wake_o),  16'h000F);
      advance();
      set_in(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
      repeat (3) step();

      // Depth-3 wrap-around: one element in flight, ten push/pop pairs
      set_in(1'b1, 1'b0, 8'h01, 4'h0, 1'b0);
      step();
      for (int k = 1; k <= 10; k++) begin
         logic [3:0] kv;
         kv = 4'(k);
         set_in(1'b1, 1'b0, {kv, 4'h1}, 4'h1, 1'b0);
         sample();
         chk($sformatf("wrap%0d dst", k), 16'(bus1.dst_o[3:0]), 16'(k - 1));
         chk($sformatf("wrap%0d lvl", k), 16'(bus1.level_o[1:0]), 16'h0001);
         advance();
      end
      set_in(1'b0, 1'b0, 8'h00, 4'h1, 1'b0);
      repeat (3) step();

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [7:0] rd;
         logic [3:0] rp;
         rd = 8'($urandom);
         rp = 4'($urandom) & 4'($urandom);
         set_in(1'($urandom), 1'($urandom), rd, rp, ($urandom_range(0, 15) == 0));
         step();
      end

      // Fill every FIFO to two entries, then reset asynchronously mid-cycle
      set_in(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
      repeat (4) step();
      set_in(1'b1, 1'b0, 8'h0F, 4'h0, 1'b0);
      repeat (2) step();
      set_in(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      repeat (2) step();
      chk("pre-rst lvl0", 16'(bus0.level_o), 16'h00AA);
      chk("pre-rst lvl1", 16'(bus1.level_o), 16'h00AA);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst empty0", 16'(bus0.empty_o), 16'h000F);
      chk("rst empty1", 16'(bus1.empty_o), 16'h000F);
      chk("rst lvl0",   16'(bus0.level_o), 16'h0000);
      chk("rst lvl1",   16'(bus1.level_o), 16'h0000);
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      set_in(1'b1, 1'b0, 8'h54, 4'h0, 1'b0);
      step();
      set_in(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
      sample();
      chk("post-rst empty", 16'(bus0.empty_o), 16'h000B);
      chk("post-rst dst",   bus0.dst_o,        16'h0500);
      chk("post-rst lvl",   16'(bus0.level_o), 16'h0010);
      advance();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
